// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default frame geometry for the UART transmit scheduler
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // set when requester 1 won most recently, so requester 0 takes the next tie
  logic last_gnt1;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_gnt1)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      last_gnt1 <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_gnt1 <= gnt[1];
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates two byte requesters onto one oversampled UART transmit line
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [CW-1:0]        tick_cnt, tick_nxt;
  logic [IW-1:0]        bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 tx_nxt, gnt0_nxt, gnt1_nxt;
  logic                 arb_update, bit_end;
  logic [1:0]           arb_gnt;

  rr_arbiter2 u_arb (
    .sysclk (sysclk),
    .reset  (reset),
    .req    ({req1, req0}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    idx_nxt    = bit_idx;
    shreg_nxt  = shreg;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    arb_update = 1'b0;
    tx_nxt     = 1'b1;
    if ((state != ST_IDLE) && baud_tick) begin
      tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);
    end
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          arb_update = 1'b1;
          state_nxt  = ST_START;
          tick_nxt   = '0;
          idx_nxt    = '0;
          shreg_nxt  = arb_gnt[1] ? data1 : data0;
          gnt0_nxt   = arb_gnt[0];
          gnt1_nxt   = arb_gnt[1];
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          idx_nxt   = bit_idx + IW'(1);
          if (bit_idx == IDX_LAST) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // tx is registered from the next state so the line changes only on clock edges
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shreg_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_idx  <= idx_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench: frame scoreboard, table vectors and corner sequences
module tb_uart_tx_scheduler;

  logic       sysclk, reset, baud_tick, req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, tx, busy;

  uart_tx_scheduler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .tx        (tx),
    .busy      (busy)
  );

  typedef struct {
    int         who;
    logic [7:0] data;
    bit         chk_gap;
  } exp_t;

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         first;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  int total = 0;
  int bad = 0;
  int aborted = 0;
  bit tick_en;
  int phase = 0;

  logic [9:0] slot_val;
  int mon_slot, mon_ticks, idle_cnt, mon_gap, mon_who;
  bit mon_in_frame = 0, slot_first, mon_stable, first_sample, proto_err = 0;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // one baud_tick every fourth cycle, changed just after the rising edge
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      baud_tick = tick_en && (phase == 0);
      phase = (phase + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic end_frame();
    exp_t e;
    check("frame_expected", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("frame_who", mon_who, e.who);
    check("frame_data", slot_val[8:1], e.data);
    check("start_bit", slot_val[0], 0);
    check("stop_bit", slot_val[9], 1);
    check("bit_stable", mon_stable, 1);
    if (e.chk_gap) check("idle_gap", mon_gap, 1);
    else check("idle_gap_min", mon_gap >= 1, 1);
  endtask

  // monitor: rebuilds each frame from tx, counting the baud_ticks it sees to place bit boundaries
  always @(negedge sysclk) begin
    if (reset) begin
      if (mon_in_frame) begin
        aborted++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      mon_in_frame = 0;
      idle_cnt = 0;
    end else begin
      if (!mon_in_frame) begin
        if (gnt0 || gnt1) begin
          mon_in_frame = 1;
          mon_who = gnt1 ? 1 : 0;
          mon_gap = idle_cnt;
          mon_slot = 0;
          mon_ticks = 0;
          slot_first = 1;
          mon_stable = 1;
          first_sample = 1;
          if (gnt0 && gnt1) proto_err = 1;
        end else begin
          idle_cnt++;
          if (busy !== 1'b0 || tx !== 1'b1) proto_err = 1;
        end
      end
      if (mon_in_frame) begin
        if (slot_first) begin
          slot_val[mon_slot] = tx;
          slot_first = 0;
        end else if (tx !== slot_val[mon_slot]) begin
          mon_stable = 0;
        end
        if (busy !== 1'b1) mon_stable = 0;
        if (!first_sample && (gnt0 || gnt1)) proto_err = 1;
        first_sample = 0;
        if (baud_tick) begin
          mon_ticks++;
          if (mon_ticks == 16) begin
            mon_ticks = 0;
            mon_slot++;
            slot_first = 1;
            if (mon_slot == 10) begin
              mon_in_frame = 0;
              idle_cnt = 0;
              end_frame();
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic run_vec(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
    int n = 0;
    data0 = d0;
    data1 = d1;
    req0 = r0;
    req1 = r1;
    while ((req0 || req1) && n < 3000) begin
      step();
      n++;
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
    check("grant_timeout", n >= 3000, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || mon_in_frame || busy) && n < 6000) begin
      step();
      n++;
    end
    check("drain_timeout", n >= 6000, 0);
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (!(mon_in_frame && mon_slot == s) && n < 3000) begin
      step();
      n++;
    end
    check("slot_timeout", n >= 3000, 0);
  endtask

  initial begin
    int cnt;
    int n;
    bit stall_bad;

    vecs[0] = '{1, 1, 8'h11, 8'h22, 0};
    vecs[1] = '{1, 0, 8'hA5, 8'h00, 0};
    vecs[2] = '{0, 1, 8'h00, 8'h3C, 1};
    vecs[3] = '{1, 1, 8'h00, 8'hFF, 0};
    vecs[4] = '{0, 1, 8'h00, 8'h80, 1};
    vecs[5] = '{1, 0, 8'h01, 8'h00, 0};
    vecs[6] = '{1, 1, 8'h5A, 8'hC3, 1};
    vecs[7] = '{0, 1, 8'h00, 8'h7E, 1};

    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    tick_en = 1'b1;
    #3;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].r0 && vecs[i].r1) begin
        exp_q.push_back('{vecs[i].first, (vecs[i].first == 1) ? vecs[i].d1 : vecs[i].d0, 1'b0});
        exp_q.push_back('{1 - vecs[i].first, (vecs[i].first == 1) ? vecs[i].d0 : vecs[i].d1, 1'b1});
      end else begin
        exp_q.push_back('{vecs[i].r1 ? 1 : 0, vecs[i].r1 ? vecs[i].d1 : vecs[i].d0, 1'b0});
      end
      run_vec(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
      drain();
    end

    // both requesters held through four frames
    exp_q.push_back('{0, 8'h69, 1'b0});
    exp_q.push_back('{1, 8'hD2, 1'b1});
    exp_q.push_back('{0, 8'h69, 1'b1});
    exp_q.push_back('{1, 8'hD2, 1'b1});
    data0 = 8'h69;
    data1 = 8'hD2;
    req0 = 1'b1;
    req1 = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 8000) begin
      step();
      n++;
      if (gnt0 || gnt1) cnt++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("hold_timeout", n >= 8000, 0);
    drain();

    // requester 1 arrives during data bit 3 and must wait for the stop bit
    exp_q.push_back('{0, 8'h33, 1'b0});
    exp_q.push_back('{1, 8'hCC, 1'b1});
    data0 = 8'h33;
    req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 100) begin step(); n++; end
    req0 = 1'b0;
    check("mid_gnt0_timeout", n >= 100, 0);
    wait_slot(4);
    data1 = 8'hCC;
    req1 = 1'b1;
    n = 0;
    while (!gnt1 && n < 3000) begin step(); n++; end
    req1 = 1'b0;
    check("mid_gnt1_timeout", n >= 3000, 0);
    drain();

    // baud_tick withheld for 1000 cycles in START
    exp_q.push_back('{0, 8'hE7, 1'b0});
    data0 = 8'hE7;
    req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 100) begin step(); n++; end
    tick_en = 1'b0;
    req0 = 1'b0;
    check("stall_gnt_timeout", n >= 100, 0);
    stall_bad = 0;
    repeat (1000) begin
      step();
      if (tx !== 1'b0 || busy !== 1'b1 || mon_slot != 0) stall_bad = 1;
    end
    check("stall_hold", stall_bad, 0);
    tick_en = 1'b1;
    drain();

    // reset in data bit 5, then a tie that must go to requester 0 again
    exp_q.push_back('{0, 8'h96, 1'b0});
    data0 = 8'h96;
    req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 100) begin step(); n++; end
    req0 = 1'b0;
    check("rst_gnt_timeout", n >= 100, 0);
    wait_slot(6);
    reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_gnt", {gnt1, gnt0}, 0);
    step();
    step();
    check("midrst_dropped", exp_q.size(), 0);
    reset = 1'b0;
    exp_q.push_back('{0, 8'h4B, 1'b0});
    exp_q.push_back('{1, 8'h77, 1'b1});
    run_vec(1'b1, 1'b1, 8'h4B, 8'h77);
    drain();

    check("abort_count", aborted, 1);
    check("gnt_protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
